// File: rtl/axon_pkg.sv
// Shared definitions for the AXON psum drain slice.
//   - drain_state_e   : drain controller FSM encoding
//   - DATA_WIDTH_DEF  : default psum word width (must match the PE row)
//   - count_width()   : width of an occupancy counter able to hold 0..depth
package axon_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_SPACE = 2'd1,
    ST_EJECT      = 2'd2,
    ST_SHIFT      = 2'd3
  } drain_state_e;

  // Occupancy counters must represent the full value, hence the +1.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axon_psum_drain_if.sv
// Valid/ready psum stream from the drain FIFO to writeback.
//   m_data  : head word
//   m_last  : head word is the last word of a frame
//   m_valid : head word present
//   m_ready : consumer accepts the head word
interface axon_psum_drain_if
  import axon_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);

  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  m_valid;
  logic                  m_ready;

  modport master (output m_data, output m_last, output m_valid, input m_ready);
  modport slave  (input m_data, input m_last, input m_valid, output m_ready);

endinterface

// File: rtl/axon_sync_fifo.sv
// Show-ahead synchronous FIFO with sticky overflow flag.
//   clk, rst_n : clock, async active-low reset
//   push, din  : write request and payload (dropped when full without a pop)
//   pop, dout  : read request and head payload (zero while empty)
//   empty/full : occupancy flags
//   count      : current occupancy 0..DEPTH
//   overflow   : sticky, set by a dropped push
module axon_sync_fifo
  import axon_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH_DEF + 1,
  parameter int unsigned DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            push,
  input  logic                            pop,
  input  logic [WIDTH-1:0]                din,
  output logic [WIDTH-1:0]                dout,
  output logic                            empty,
  output logic                            full,
  output logic [count_width(DEPTH)-1:0]   count,
  output logic                            overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = count_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign overflow = ovf_q;
  // Zero while empty so the stream bus is quiet between frames.
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer/count/flag next state; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    if (push && !do_push) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: dout is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/axon_psum_drain.sv
// Psum drain for the AXON horizontal PE row: pulses the broadcast eject,
// captures NUM_PE psums shifting out of the chain, and streams them out
// through a FIFO with a frame-last flag.
//   clk, rst_n         : clock, async active-low reset
//   drain_start        : one-cycle request to drain one frame
//   drain_busy         : controller not idle
//   output_eject_ctrl  : one-cycle broadcast eject to the PE row
//   chain_in           : psum chain output of PE NUM_PE-1
//   m_if (master)      : valid/ready output stream with m_last
//   fifo_count         : FIFO occupancy
//   overflow_err       : sticky FIFO overflow
// Build option: AXON_DRAIN_RELU_EN clamps negative psums to zero before the FIFO.
module axon_psum_drain
  import axon_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned NUM_PE     = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  drain_start,
  output logic                                  drain_busy,
  output logic                                  output_eject_ctrl,
  input  logic [DATA_WIDTH-1:0]                 chain_in,
  axon_psum_drain_if.master                     m_if,
  output logic [count_width(FIFO_DEPTH)-1:0]    fifo_count,
  output logic                                  overflow_err
);

  localparam int unsigned CNT_W   = count_width(FIFO_DEPTH);
  localparam int unsigned SHIFT_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int unsigned FIFO_W  = DATA_WIDTH + 1;

  drain_state_e          state_q, state_d;
  logic [SHIFT_W-1:0]    shift_cnt_q, shift_cnt_d;
  logic                  eject_q, busy_q;
  logic                  has_space;
  logic                  last_word;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] push_data;
  logic [FIFO_W-1:0]     fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_full_unused;

  // A whole frame must fit before ejecting, which keeps the FIFO from overflowing.
  assign has_space = (CNT_W'(FIFO_DEPTH) - fifo_count) >= CNT_W'(NUM_PE);
  assign last_word = (shift_cnt_q == SHIFT_W'(NUM_PE - 1));

`ifdef AXON_DRAIN_RELU_EN
  assign push_data = chain_in[DATA_WIDTH-1] ? '0 : chain_in;
`else
  assign push_data = chain_in;
`endif

  // Next state, shift counter and FIFO push.
  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    push        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (drain_start) state_d = has_space ? ST_EJECT : ST_WAIT_SPACE;
      end
      ST_WAIT_SPACE: begin
        if (has_space) state_d = ST_EJECT;
      end
      ST_EJECT: begin
        state_d     = ST_SHIFT;
        shift_cnt_d = '0;
      end
      ST_SHIFT: begin
        push = 1'b1;
        if (last_word) begin
          state_d     = ST_IDLE;
          shift_cnt_d = '0;
        end else begin
          shift_cnt_d = shift_cnt_q + SHIFT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State plus flop-decoded eject/busy so both come straight from registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shift_cnt_q <= '0;
      eject_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      eject_q     <= (state_d == ST_EJECT);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign output_eject_ctrl = eject_q;
  assign drain_busy        = busy_q;

  assign pop = m_if.m_valid & m_if.m_ready;

  axon_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .din      ({last_word, push_data}),
    .dout     (fifo_dout),
    .empty    (fifo_empty),
    .full     (fifo_full_unused),
    .count    (fifo_count),
    .overflow (overflow_err)
  );

  assign m_if.m_data  = fifo_dout[DATA_WIDTH-1:0];
  assign m_if.m_last  = fifo_dout[DATA_WIDTH];
  assign m_if.m_valid = ~fifo_empty;

endmodule
